// File: rtl/gbvga_pkg.sv
// Shared constants and types for the Game Boy LCD capture and VGA scan-out path.
package gbvga_pkg;

  localparam int unsigned GB_H_PIXELS = 160;
  localparam int unsigned GB_V_LINES  = 144;
  localparam int unsigned FB_ADDR_W   = 15;

  typedef logic [1:0] pixel_t;

  typedef enum logic [0:0] {
    WAIT_FRAME = 1'b0,
    ACTIVE     = 1'b1
  } cap_state_t;

endpackage

// File: rtl/gb_sync_edge.sv
// Multi-flop synchronizer for one async level with combinational rise/fall detect.
module gb_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync;
  logic              hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      hist <= sync[STAGES-1];
    end
  end

  assign rise_c = sync[STAGES-1] & ~hist;
  assign fall_c = ~sync[STAGES-1] & hist;

endmodule

// File: rtl/gb_lcd_capture.sv
// Captures the GB LCD pixel stream into framebuffer writes (addr = y*H_PIXELS + x).
// Define GB_CAPTURE_DOUBLE_BUFFER_EN for a ping-pong framebuffer with a bank output.
module gb_lcd_capture
  import gbvga_pkg::*;
#(
  parameter int unsigned H_PIXELS    = GB_H_PIXELS,
  parameter int unsigned V_LINES     = GB_V_LINES,
  parameter int unsigned ADDR_W      = FB_ADDR_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gb_clk,
  input  logic              gb_hsync,
  input  logic              gb_vsync,
  input  logic [1:0]        gb_data,
  output logic              wr_en,
`ifdef GB_CAPTURE_DOUBLE_BUFFER_EN
  output logic [ADDR_W:0]   wr_addr,
  output logic              bank,
`else
  output logic [ADDR_W-1:0] wr_addr,
`endif
  output pixel_t            wr_data,
  output logic              frame_done,
  output logic              line_err,
  output logic              capturing
);

  localparam int unsigned X_W = $clog2(H_PIXELS + 1);
  localparam int unsigned Y_W = $clog2(V_LINES);
`ifdef GB_CAPTURE_DOUBLE_BUFFER_EN
  localparam int unsigned OUT_W = ADDR_W + 1;
`else
  localparam int unsigned OUT_W = ADDR_W;
`endif

  localparam logic [X_W-1:0]    X_END    = X_W'(H_PIXELS);
  localparam logic [X_W-1:0]    X_LAST   = X_W'(H_PIXELS - 1);
  localparam logic [Y_W-1:0]    Y_LAST   = Y_W'(V_LINES - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_PIXELS);

  logic px_fall_c, px_rise_c;
  logic hs_rise_c, hs_fall_c;
  logic vs_rise_c, vs_fall_c;
  logic unused_edges;

  gb_sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (gb_clk),
    .rise_c (px_rise_c),
    .fall_c (px_fall_c)
  );

  gb_sync_edge #(.STAGES(SYNC_STAGES)) u_hs_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (gb_hsync),
    .rise_c (hs_rise_c),
    .fall_c (hs_fall_c)
  );

  gb_sync_edge #(.STAGES(SYNC_STAGES)) u_vs_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (gb_vsync),
    .rise_c (vs_rise_c),
    .fall_c (vs_fall_c)
  );

  assign unused_edges = ^{px_rise_c, hs_fall_c, vs_fall_c};

  // Data goes through the same depth so it lines up with the synced pixel clock.
  logic [SYNC_STAGES-1:0][1:0] data_sync;
  logic   px_ev, hs_ev, vs_ev;
  pixel_t px_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_sync <= '0;
      px_ev     <= 1'b0;
      hs_ev     <= 1'b0;
      vs_ev     <= 1'b0;
      px_data   <= '0;
    end else begin
      data_sync <= {data_sync[SYNC_STAGES-2:0], gb_data};
      px_ev     <= px_fall_c;
      hs_ev     <= hs_rise_c;
      vs_ev     <= vs_rise_c;
      if (px_fall_c) px_data <= data_sync[SYNC_STAGES-1];
    end
  end

  cap_state_t        state, state_n;
  logic [X_W-1:0]    x, x_n;
  logic [Y_W-1:0]    y, y_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [ADDR_W-1:0] row_base, row_n;
  logic              done_pend, done_pend_n;
  logic              wr_en_n;
  logic [OUT_W-1:0]  wr_addr_n;
  pixel_t            wr_data_n;
  logic              frame_done_n;
  logic              line_err_n;
`ifdef GB_CAPTURE_DOUBLE_BUFFER_EN
  logic              bank_n;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_FRAME;
      x          <= '0;
      y          <= '0;
      addr       <= '0;
      row_base   <= '0;
      done_pend  <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      capturing  <= 1'b0;
`ifdef GB_CAPTURE_DOUBLE_BUFFER_EN
      bank       <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      x          <= x_n;
      y          <= y_n;
      addr       <= addr_n;
      row_base   <= row_n;
      done_pend  <= done_pend_n;
      wr_en      <= wr_en_n;
      wr_addr    <= wr_addr_n;
      wr_data    <= wr_data_n;
      frame_done <= frame_done_n;
      line_err   <= line_err_n;
      capturing  <= (state_n == ACTIVE);
`ifdef GB_CAPTURE_DOUBLE_BUFFER_EN
      bank       <= bank_n;
`endif
    end
  end

  // Per cycle: vsync restart, else hsync line advance, then pixel at the updated position.
  always_comb begin
    state_n      = state;
    x_n          = x;
    y_n          = y;
    addr_n       = addr;
    row_n        = row_base;
    done_pend_n  = 1'b0;
    wr_en_n      = 1'b0;
    wr_addr_n    = wr_addr;
    wr_data_n    = wr_data;
    frame_done_n = done_pend;
    line_err_n   = line_err;
`ifdef GB_CAPTURE_DOUBLE_BUFFER_EN
    bank_n       = bank ^ done_pend;
`endif
    case (state)
      WAIT_FRAME: begin
        if (vs_ev) begin
          state_n    = ACTIVE;
          x_n        = '0;
          y_n        = '0;
          addr_n     = '0;
          row_n      = '0;
          line_err_n = 1'b0;
        end
      end
      ACTIVE: begin
        if (vs_ev) begin
          x_n        = '0;
          y_n        = '0;
          addr_n     = '0;
          row_n      = '0;
          line_err_n = 1'b0;
        end else if (hs_ev) begin
          if (y == Y_LAST) begin
            line_err_n = 1'b1;
            state_n    = WAIT_FRAME;
          end else begin
            x_n    = '0;
            y_n    = y + Y_W'(1);
            row_n  = row_base + ROW_STEP;
            addr_n = row_base + ROW_STEP;
          end
        end
        if (px_ev && (state_n == ACTIVE)) begin
          if (x_n != X_END) begin
            wr_en_n   = 1'b1;
`ifdef GB_CAPTURE_DOUBLE_BUFFER_EN
            wr_addr_n = {~bank, addr_n};
`else
            wr_addr_n = addr_n;
`endif
            wr_data_n = px_data;
            if ((x_n == X_LAST) && (y_n == Y_LAST)) begin
              done_pend_n = 1'b1;
              state_n     = WAIT_FRAME;
            end
            addr_n = addr_n + ADDR_W'(1);
            x_n    = x_n + X_W'(1);
          end else begin
            line_err_n = 1'b1;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_gb_lcd_capture.sv
// Randomized bench for gb_lcd_capture against an event-level framebuffer model.
module tb_gb_lcd_capture;

  localparam int unsigned TB_H    = 160;
  localparam int unsigned TB_SYNC = 2;
`ifdef GB_CAPTURE_DOUBLE_BUFFER_EN
  localparam int unsigned TB_V      = 64;
  localparam int unsigned TB_AW     = 16;
  localparam int          N_FRAMES  = 2;
`else
  localparam int unsigned TB_V      = 144;
  localparam int unsigned TB_AW     = 15;
  localparam int          N_FRAMES  = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             gb_clk, gb_hsync, gb_vsync;
  logic [1:0]       gb_data;
  logic             wr_en;
  logic [TB_AW-1:0] wr_addr;
  logic [1:0]       wr_data;
  logic             frame_done, line_err, capturing;
`ifdef GB_CAPTURE_DOUBLE_BUFFER_EN
  logic             bank;
`endif

  gb_lcd_capture #(
    .H_PIXELS    (TB_H),
    .V_LINES     (TB_V),
    .ADDR_W      (15),
    .SYNC_STAGES (TB_SYNC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gb_clk     (gb_clk),
    .gb_hsync   (gb_hsync),
    .gb_vsync   (gb_vsync),
    .gb_data    (gb_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
`ifdef GB_CAPTURE_DOUBLE_BUFFER_EN
    .bank       (bank),
`endif
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .line_err   (line_err),
    .capturing  (capturing)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame/line/pixel rules applied per GB event.
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  data;
  } exp_t;

  exp_t exp_q[$];
  bit   m_active = 1'b0;
  bit   m_err    = 1'b0;
  int   m_x = 0, m_y = 0, m_done = 0;
  int   done_seen = 0;
  bit   prev_wr = 1'b0;

  task automatic m_vsync();
    m_active = 1'b1; m_x = 0; m_y = 0; m_err = 1'b0;
  endtask

  task automatic m_hsync();
    if (m_active) begin
      if (m_y == TB_V - 1) begin
        m_err = 1'b1; m_active = 1'b0;
      end else begin
        m_x = 0; m_y++;
      end
    end
  endtask

  task automatic m_pixel(input logic [1:0] d);
    exp_t e;
    if (m_active) begin
      if (m_x < TB_H) begin
        e.addr = m_y * TB_H + m_x;
`ifdef GB_CAPTURE_DOUBLE_BUFFER_EN
        if (m_done % 2 == 0) e.addr = e.addr + (1 << 15);
`endif
        e.data = d;
        exp_q.push_back(e);
        m_x++;
        if (m_x == TB_H && m_y == TB_V - 1) begin
          m_active = 1'b0; m_done++;
        end
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic m_reset();
    m_active = 1'b0; m_err = 1'b0; m_x = 0; m_y = 0;
  endtask

  // Write-port monitor, sampled on the falling clock edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (wr_en) begin
        if (exp_q.size() == 0) check_eq("unexpected_wr", 1, 0);
        else begin
          e = exp_q.pop_front();
          check_eq("wr_addr", 32'(wr_addr), e.addr);
          check_eq("wr_data", 32'(wr_data), 32'(e.data));
        end
      end
      if (frame_done) begin
        done_seen++;
        check_eq("done_after_last_wr", 32'(prev_wr), 1);
      end
      prev_wr = wr_en;
    end
  end

  // GB-side drivers; all changes happen on the falling clk edge.
  task automatic pixel(input logic [1:0] d, input int gap);
    gb_data = d; gb_clk = 1'b0; m_pixel(d);
    @(negedge clk); gb_clk = 1'b1;
    repeat (1 + gap) @(negedge clk);
  endtask

  task automatic hsync();
    gb_hsync = 1'b1; m_hsync();
    repeat (2) @(negedge clk); gb_hsync = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic vsync();
    gb_vsync = 1'b1; m_vsync();
    repeat (2) @(negedge clk); gb_vsync = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pixel_latency(input logic [1:0] d);
    int lat;
    lat = -1;
    gb_data = d; gb_clk = 1'b0; m_pixel(d);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (wr_en && lat < 0) lat = i;
    end
    check_eq("pixel_latency", 32'(lat), TB_SYNC + 1);
    @(negedge clk); gb_clk = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic checkpoint(input string tag);
    repeat (10) @(negedge clk);
    check_eq({tag, "_drain"}, exp_q.size(), 0);
    check_eq({tag, "_frame_done"}, done_seen, m_done);
    check_eq({tag, "_line_err"}, 32'(line_err), 32'(m_err));
    check_eq({tag, "_capturing"}, 32'(capturing), 32'(m_active));
`ifdef GB_CAPTURE_DOUBLE_BUFFER_EN
    check_eq({tag, "_bank"}, 32'(bank), m_done % 2);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_wr_en"}, 32'(wr_en), 0);
    check_eq({tag, "_wr_addr"}, 32'(wr_addr), 0);
    check_eq({tag, "_wr_data"}, 32'(wr_data), 0);
    check_eq({tag, "_frame_done"}, 32'(frame_done), 0);
    check_eq({tag, "_line_err"}, 32'(line_err), 0);
    check_eq({tag, "_capturing"}, 32'(capturing), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int reset_line;
    rst_n = 1'b0; gb_clk = 1'b1; gb_hsync = 1'b0; gb_vsync = 1'b0; gb_data = 2'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Pixels before the first vsync are ignored; then 10 pixels land at 0..9.
    for (int i = 0; i < 5; i++) pixel(2'($urandom), 0);
    hsync();
    vsync();
    pixel_latency(2'($urandom));
    for (int i = 0; i < 9; i++) pixel(2'($urandom), $urandom_range(0, 2));
    checkpoint("first10");

    // Complete frame(s) with data = (x+y)%4.
    for (int f = 0; f < N_FRAMES; f++) begin
      vsync();
      for (int yy = 0; yy < TB_V; yy++) begin
        for (int xx = 0; xx < TB_H; xx++) pixel(2'((xx + yy) % 4), 0);
        hsync();
      end
      checkpoint("full_frame");
    end

    // Line 3 carries 165 pixels: 5 dropped, sticky error until next vsync.
    vsync();
    for (int yy = 0; yy < 4; yy++) begin
      for (int xx = 0; xx < (yy == 3 ? TB_H + 5 : TB_H); xx++) pixel(2'($urandom), 0);
      hsync();
    end
    for (int i = 0; i < 3; i++) pixel(2'($urandom), $urandom_range(0, 1));
    checkpoint("line_overrun");
    vsync();
    for (int i = 0; i < 4; i++) pixel(2'($urandom), 0);
    checkpoint("err_cleared");

    // Reset mid-frame, then pixels ignored until the next vsync.
    reset_line = (TB_V > 80) ? 70 : int'(TB_V / 2);
    vsync();
    for (int yy = 0; yy < reset_line; yy++) begin
      for (int i = 0; i < int'($urandom_range(1, 3)); i++) pixel(2'($urandom), 0);
      hsync();
    end
    for (int i = 0; i < 5; i++) pixel(2'($urandom), 0);
    checkpoint("pre_reset");
    rst_n = 1'b0; m_reset();
    #1;
    check_reset_outputs("mid_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 6; i++) pixel(2'($urandom), 0);
    hsync();
    checkpoint("post_reset_idle");
    vsync();
    for (int i = 0; i < 12; i++) pixel(2'($urandom), $urandom_range(0, 2));
    checkpoint("post_reset_frame");

    // 145 hsync rises in one frame: error, no frame_done, later pixels dropped.
    vsync();
    for (int yy = 0; yy < TB_V + 1; yy++) begin
      pixel(2'($urandom), 0);
      hsync();
    end
    for (int i = 0; i < 4; i++) pixel(2'($urandom), 0);
    checkpoint("line_count_overrun");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
